// File: rtl/vector_pool_v2.sv
// vector_pool_v2: per-lane max/average pooling over variable-length windows, 2-entry output FIFO.
// Define VECTOR_POOL_V2_AVG_EN to build the sum/multiplier path and honour pool_mode.
module vector_pool_v2 #(
  parameter int LANES   = 8,
  parameter int DIN_W   = 8,
  parameter int MAX_WIN = 9,
  parameter int RELU    = 1,
  parameter int Q       = 13,
  parameter int AVG_MUL = 910
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   op_din_en,
  input  logic                   op_din_eop,
  input  logic [LANES*DIN_W-1:0] op_din,
  input  logic                   pool_mode,
  output logic                   op_din_rdy,
  output logic                   blob_dout_en,
  input  logic                   blob_dout_rdy,
  output logic [LANES*DIN_W-1:0] blob_dout,
  output logic                   ovf_err
);
  localparam int CNT_W = $clog2(MAX_WIN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WIN);

  logic                    w_acc, w_first, w_push, w_pop;
  logic signed [DIN_W-1:0] w_din     [LANES];
  logic signed [DIN_W-1:0] w_max_nxt [LANES];
  logic signed [DIN_W-1:0] w_pre     [LANES];
  logic [LANES*DIN_W-1:0]  w_res_vec;
  logic signed [DIN_W-1:0] r_max     [LANES];
  logic signed [DIN_W-1:0] r_stg_max [LANES];
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_stg_vld, r_ovf;
  logic [LANES*DIN_W-1:0]  r_fifo [2];
  logic                    r_wr_ptr, r_rd_ptr;
  logic [1:0]              r_count;

  // Ready depends only on registered occupancy; a same-cycle pop does not open the gate.
  assign op_din_rdy   = ({1'b0, r_count} + {2'b00, r_stg_vld}) < 3'd2;
  assign blob_dout_en = (r_count != 2'd0);
  assign blob_dout    = blob_dout_en ? r_fifo[r_rd_ptr] : '0;
  assign ovf_err      = r_ovf;
  assign w_acc        = op_din_en & op_din_rdy;
  assign w_first      = (r_cnt == '0);
  assign w_push       = r_stg_vld;
  assign w_pop        = blob_dout_en & blob_dout_rdy;

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      w_din[k]     = op_din[k*DIN_W +: DIN_W];
      w_max_nxt[k] = (w_first || (w_din[k] > r_max[k])) ? w_din[k] : r_max[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_stg_vld <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        r_max[k]     <= '0;
        r_stg_max[k] <= '0;
      end
    end else begin
      r_stg_vld <= w_acc & op_din_eop;
      if (w_acc) begin
        if (op_din_eop) begin
          r_cnt <= '0;
          for (int k = 0; k < LANES; k++) begin
            r_stg_max[k] <= w_max_nxt[k];
            r_max[k]     <= '0;
          end
        end else begin
          for (int k = 0; k < LANES; k++) r_max[k] <= w_max_nxt[k];
          if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
          else                  r_ovf <= 1'b1;
        end
      end
    end
  end

`ifdef VECTOR_POOL_V2_AVG_EN
  localparam int SUM_W  = DIN_W + $clog2(MAX_WIN);
  localparam int MUL_W  = $clog2(AVG_MUL + 1) + 1;
  localparam int PROD_W = SUM_W + MUL_W;
  localparam logic signed [PROD_W-1:0] MUL_C  = PROD_W'(AVG_MUL);
  localparam logic signed [PROD_W-1:0] RND    = PROD_W'(2 ** (Q - 1));
  localparam logic signed [PROD_W-1:0] SAT_HI = PROD_W'(2 ** (DIN_W - 1) - 1);
  localparam logic signed [PROD_W-1:0] SAT_LO = PROD_W'(-(2 ** (DIN_W - 1)));
  localparam logic signed [DIN_W-1:0]  D_MAX  = DIN_W'(2 ** (DIN_W - 1) - 1);
  localparam logic signed [DIN_W-1:0]  D_MIN  = DIN_W'(-(2 ** (DIN_W - 1)));

  logic signed [SUM_W-1:0]  w_din_ext [LANES];
  logic signed [SUM_W-1:0]  w_sum_nxt [LANES];
  logic signed [SUM_W-1:0]  r_sum     [LANES];
  logic signed [SUM_W-1:0]  r_stg_sum [LANES];
  logic signed [PROD_W-1:0] w_scaled  [LANES];
  logic                     w_mode, r_mode, r_stg_mode;

  assign w_mode = w_first ? pool_mode : r_mode;

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      w_din_ext[k] = {{(SUM_W-DIN_W){w_din[k][DIN_W-1]}}, w_din[k]};
      w_sum_nxt[k] = w_first ? w_din_ext[k] : (r_sum[k] + w_din_ext[k]);
      w_scaled[k]  = (PROD_W'(r_stg_sum[k]) * MUL_C + RND) >>> Q;
      if (!r_stg_mode)               w_pre[k] = r_stg_max[k];
      else if (w_scaled[k] > SAT_HI) w_pre[k] = D_MAX;
      else if (w_scaled[k] < SAT_LO) w_pre[k] = D_MIN;
      else                           w_pre[k] = w_scaled[k][DIN_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode     <= 1'b0;
      r_stg_mode <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        r_sum[k]     <= '0;
        r_stg_sum[k] <= '0;
      end
    end else if (w_acc) begin
      r_mode <= w_mode;
      if (op_din_eop) begin
        r_stg_mode <= w_mode;
        for (int k = 0; k < LANES; k++) begin
          r_stg_sum[k] <= w_sum_nxt[k];
          r_sum[k]     <= '0;
        end
      end else begin
        for (int k = 0; k < LANES; k++) r_sum[k] <= w_sum_nxt[k];
      end
    end
  end
`else
  logic w_unused;
  assign w_unused = pool_mode;

  always_comb begin
    for (int k = 0; k < LANES; k++) w_pre[k] = r_stg_max[k];
  end
`endif

  always_comb begin
    w_res_vec = '0;
    for (int k = 0; k < LANES; k++) begin
      w_res_vec[k*DIN_W +: DIN_W] = ((RELU != 0) && w_pre[k][DIN_W-1]) ? '0 : w_pre[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_res_vec;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_vector_pool_v2.sv
// tb_vector_pool_v2: table-driven windows plus hand sequences, checked through a result scoreboard.
module tb_vector_pool_v2;
`ifdef VECTOR_POOL_V2_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  typedef struct {
    logic [63:0] din;
    logic        eop;
    logic        mode;
    logic [7:0]  exp0;
  } vec_t;

  typedef struct {
    logic [63:0] word;
    logic        has0;
    logic [7:0]  exp0;
  } exp_t;

  logic        clk = 1'b0, rst = 1'b0;
  logic        op_din_en = 1'b0, op_din_eop = 1'b0, pool_mode = 1'b0;
  logic [63:0] op_din = '0;
  logic        op_din_rdy, blob_dout_en, ovf_err;
  logic        blob_dout_rdy = 1'b0;
  logic [63:0] blob_dout;

  int   n_vec = 0, n_err = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  vec_t tbl[$];
  int   mx[8], sm[8];
  int   wcnt = 0;
  logic wmode = 1'b0, exp_ovf = 1'b0;

  always #5 clk = ~clk;

  vector_pool_v2 #(.LANES(8), .DIN_W(8), .MAX_WIN(9), .RELU(1), .Q(13), .AVG_MUL(910)) dut (
    .clk(clk), .rst(rst), .op_din_en(op_din_en), .op_din_eop(op_din_eop), .op_din(op_din),
    .pool_mode(pool_mode), .op_din_rdy(op_din_rdy), .blob_dout_en(blob_dout_en),
    .blob_dout_rdy(blob_dout_rdy), .blob_dout(blob_dout), .ovf_err(ovf_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mkw(input int v0);
    logic [63:0] w;
    w = '0;
    w[7:0] = v0[7:0];
    for (int k = 1; k < 8; k++) w[k*8 +: 8] = 8'($urandom_range(255, 0));
    return w;
  endfunction

  task automatic add_row(input int v0, input logic eop, input logic mode, input int exp0);
    vec_t r;
    r.din  = mkw(v0);
    r.eop  = eop;
    r.mode = mode;
    r.exp0 = exp0[7:0];
    tbl.push_back(r);
  endtask

  // Reference behaviour: running max/sum per lane, average scaled by 910/2^13, then ReLU.
  task automatic model_accept(input logic [63:0] d, input logic e, input logic m,
                              input logic has0, input logic [7:0] e0);
    int   v, r;
    exp_t x;
    for (int k = 0; k < 8; k++) begin
      v = $signed(d[k*8 +: 8]);
      if (wcnt == 0) begin
        mx[k] = v;
        sm[k] = v;
      end else begin
        if (v > mx[k]) mx[k] = v;
        sm[k] += v;
      end
    end
    if (wcnt == 0) wmode = m;
    if (!e && wcnt >= 9) exp_ovf = 1'b1;
    wcnt++;
    if (e) begin
      x.word = '0;
      for (int k = 0; k < 8; k++) begin
        if (AVG && wmode) begin
          r = (sm[k] * 910 + 4096) >>> 13;
          if (r > 127)  r = 127;
          if (r < -128) r = -128;
        end else begin
          r = mx[k];
        end
        if (r < 0) r = 0;
        x.word[k*8 +: 8] = r[7:0];
      end
      x.has0 = has0;
      x.exp0 = e0;
      exp_q.push_back(x);
      wcnt = 0;
    end
  endtask

  task automatic send(input logic [63:0] d, input logic e, input logic m,
                      input logic has0, input logic [7:0] e0);
    int guard;
    guard = 0;
    op_din = d; op_din_eop = e; pool_mode = m; op_din_en = 1'b1;
    while (!op_din_rdy && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!op_din_rdy) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: op_din_rdy got 0 required 1");
      op_din_en = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(d, e, m, has0, e0);
    #1 op_din_en = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  always @(negedge clk) begin
    if (!rst && blob_dout_en && blob_dout_rdy) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_output: got %h, required no output", blob_dout);
      end else begin
        mon_e = exp_q.pop_front();
        chk("dout_word", blob_dout, mon_e.word);
        if (mon_e.has0) chk("dout_lane0", {56'd0, blob_dout[7:0]}, {56'd0, mon_e.exp0});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   seq0[9];
    logic seen;
    seq0 = '{-3, 5, 2, -8, 7, 1, 0, 4, 6};

    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_dout_en", blob_dout_en, 0);
    chk("reset_dout", blob_dout, 0);
    chk("reset_ovf", ovf_err, 0);
    chk("reset_rdy", op_din_rdy, 1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    blob_dout_rdy = 1'b1;

    for (int i = 0; i < 9; i++) add_row(seq0[i], i == 8, 1'b0, 7);
    for (int i = 0; i < 9; i++) add_row(9, i == 8, 1'b1, 9);
    for (int i = 0; i < 9; i++) add_row(-100, i == 8, 1'b1, 0);
    add_row(100, 1'b1, 1'b0, 100);
    add_row(-5, 1'b1, 1'b1, 0);
    add_row(10, 1'b0, 1'b1, 0);
    add_row(20, 1'b0, 1'b0, 0);
    add_row(31, 1'b1, 1'b0, AVG ? 7 : 31);
    add_row(5, 1'b0, 1'b1, 0);
    add_row(-3, 1'b1, 1'b1, AVG ? 0 : 5);
    add_row(127, 1'b1, 1'b0, 127);
    add_row(127, 1'b1, 1'b1, AVG ? 14 : 127);

    for (int i = 0; i < tbl.size(); i++) begin
      send(tbl[i].din, tbl[i].eop, tbl[i].mode, tbl[i].eop, tbl[i].exp0);
      if (i == 8) begin
        chk("latency_cycle1_en", blob_dout_en, 0);
        @(posedge clk); #1;
        chk("latency_cycle2_en", blob_dout_en, 1);
      end
    end
    wait_drain();

    // backpressure: two windows fit, the third must wait for a pop
    blob_dout_rdy = 1'b0;
    send(mkw(11), 1'b1, 1'b0, 1'b1, 8'd11);
    send(mkw(22), 1'b1, 1'b0, 1'b1, 8'd22);
    op_din = mkw(33); op_din_eop = 1'b1; pool_mode = 1'b0; op_din_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("bp_rdy_low", op_din_rdy, 0);
    chk("bp_en_high", blob_dout_en, 1);
    op_din_en = 1'b0;
    blob_dout_rdy = 1'b1;
    @(posedge clk); #1;
    blob_dout_rdy = 1'b0;
    chk("bp_rdy_after_pop", op_din_rdy, 1);
    send(mkw(33), 1'b1, 1'b0, 1'b1, 8'd33);
    blob_dout_rdy = 1'b1;
    wait_drain();

    // simultaneous push (stage) and pop (head) keeps one entry
    blob_dout_rdy = 1'b0;
    send(mkw(44), 1'b1, 1'b0, 1'b1, 8'd44);
    repeat (2) @(posedge clk);
    #1;
    send(mkw(55), 1'b1, 1'b0, 1'b1, 8'd55);
    chk("pp_rdy_full", op_din_rdy, 0);
    blob_dout_rdy = 1'b1;
    @(posedge clk); #1;
    chk("pp_en_after", blob_dout_en, 1);
    chk("pp_rdy_after", op_din_rdy, 1);
    wait_drain();

    // overflow: ten elements without eop
    chk("ovf_before", ovf_err, 0);
    for (int i = 0; i < 10; i++) begin
      send(mkw(i * 3 - 10), 1'b0, 1'b0, 1'b0, 8'd0);
      if (i == 8) chk("ovf_at_9", ovf_err, 0);
    end
    chk("ovf_at_10", ovf_err, 1);
    chk("ovf_model", ovf_err, exp_ovf);
    send(mkw(1), 1'b1, 1'b0, 1'b1, 8'd17);
    chk("ovf_after_eop", ovf_err, 1);
    wait_drain();

    // reset mid-window with a pending result
    blob_dout_rdy = 1'b0;
    send(mkw(77), 1'b1, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 4; i++) send(mkw(i + 1), 1'b0, 1'b0, 1'b0, 8'd0);
    rst = 1'b1;
    #2;
    chk("rst_ovf_cleared", ovf_err, 0);
    chk("rst_en", blob_dout_en, 0);
    chk("rst_rdy", op_din_rdy, 1);
    chk("rst_dout", blob_dout, 0);
    exp_q.delete();
    wcnt = 0;
    exp_ovf = 1'b0;
    @(negedge clk) rst = 1'b0;
    blob_dout_rdy = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (blob_dout_en) seen = 1'b1;
    end
    chk("rst_no_output", seen, 0);
    send(mkw(5), 1'b1, 1'b0, 1'b1, 8'd5);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vector_pool_v2.md
VECTOR_POOL_V2 -- requirements
Module: vector_pool_v2

Interface
REQ-001 The block SHALL have parameter LANES, default 8, giving the number of parallel channel lanes.
REQ-002 The block SHALL have parameter DIN_W, default 8, giving the signed two's-complement width of each lane.
REQ-003 The block SHALL have parameter MAX_WIN, default 9, giving the maximum number of elements per pooling window.
REQ-004 The block SHALL have parameter RELU, default 1; when 1, negative results are clamped to 0.
REQ-005 The block SHALL have parameter Q, default 13, giving the fixed-point shift for average scaling.
REQ-006 The block SHALL have parameter AVG_MUL, default 910, giving the unsigned reciprocal of the window size scaled by 2^Q.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 The block SHALL have port op_din_en, input, 1 bit: input element valid.
REQ-010 The block SHALL have port op_din_eop, input, 1 bit: the current element is the last of its window.
REQ-011 The block SHALL have port op_din, input, LANES*DIN_W bits: lane k occupies bits [k*DIN_W +: DIN_W].
REQ-012 The block SHALL have port pool_mode, input, 1 bit: 0 = max, 1 = average; it is sampled on the first element of each window.
REQ-013 The block SHALL have port op_din_rdy, output, 1 bit: the block can accept an element.
REQ-014 The block SHALL have port blob_dout_en, output, 1 bit: output word valid.
REQ-015 The block SHALL have port blob_dout_rdy, input, 1 bit: the downstream stage accepts the output word.
REQ-016 The block SHALL have port blob_dout, output, LANES*DIN_W bits: pooled result, using the same lane packing as op_din.
REQ-017 The block SHALL have port ovf_err, output, 1 bit: sticky window-overflow flag.

Function
REQ-018 The block SHALL accept an element when op_din_en and op_din_rdy are both 1 on a rising edge; when op_din_rdy is 0, it SHALL ignore op_din_en.
REQ-019 The block SHALL load the first element of a window directly into the per-lane max register and the per-lane sum register, with no reset-value bias.
REQ-020 On each subsequent accepted element, the block SHALL update max = signed max(max, din) and sum = sum + sign-extended din.
REQ-021 The sum register SHALL be DIN_W + clog2(MAX_WIN) bits wide, so that it never wraps.
REQ-022 On acceptance of an eop element, the block SHALL load the final per-lane max/sum and the mode into a stage register (stage_vld = 1) and clear its window state.
REQ-023 The stage SHALL compute its result as follows.
- Max mode: the result is max.
- Average mode: the result is (sum*AVG_MUL + 2^(Q-1)) >>> Q, saturated to the signed DIN_W range.
- If RELU = 1, the result is then clamped to a minimum of 0.
REQ-024 On the next edge, the block SHALL write the stage result into a 2-entry output FIFO.
REQ-025 Latency: with the FIFO empty, blob_dout_en SHALL be 1 two cycles after the eop acceptance cycle.
REQ-026 op_din_rdy SHALL equal (fifo_count + stage_vld) < 2, computed from registered state only, with no pop lookahead.
REQ-027 blob_dout_en SHALL equal (fifo_count != 0), and blob_dout SHALL present the FIFO head.
REQ-028 A pop SHALL occur when blob_dout_en and blob_dout_rdy are both 1.
REQ-029 A push and a pop in the same cycle SHALL leave fifo_count unchanged and keep the data in order.
REQ-030 A window of exactly one element (eop on the first element) SHALL be valid, giving a result equal to that element (or 0 under RELU if the element is negative).
REQ-031 The element counter SHALL saturate at MAX_WIN.
REQ-032 If an element beyond the MAX_WIN-th element of a window is accepted without eop, ovf_err SHALL be set to 1 and held until reset; accumulation SHALL still continue.
REQ-033 pool_mode changes mid-window SHALL have no effect until the next window.

Reset
REQ-034 While rst = 1, the block SHALL clear the FIFO, stage_vld, the window state and ovf_err.
REQ-035 While rst = 1, the outputs SHALL be blob_dout_en = 0, blob_dout = 0, ovf_err = 0 and op_din_rdy = 1.
REQ-036 A reset asserted mid-window SHALL discard the partial window and any pending results, and the first element after reset SHALL start a new window.

Configuration
REQ-037 When macro VECTOR_POOL_V2_AVG_EN is defined, the block SHALL build the sum registers and the multiplier, and pool_mode SHALL select max or average as specified above.
REQ-038 When VECTOR_POOL_V2_AVG_EN is undefined, the block SHALL NOT build the sum or multiplier logic, SHALL ignore pool_mode, and SHALL always operate in max mode with identical latency and handshake behaviour.

Verification
REQ-039 Max window test: LANES = 8, RELU = 0, lane 0 receives 9 elements -3, 5, 2, -8, 7, 1, 0, 4, 6 with eop on the last -> blob_dout lane 0 = 7, and blob_dout_en = 1 two cycles after eop.
REQ-040 Average window test (AVG_EN defined): 9 elements, all 9, pool_mode = 1 -> sum = 81, output (81*910 + 4096) >> 13 = 9; with all elements -100 and RELU = 1 -> output 0.
REQ-041 Backpressure test: blob_dout_rdy = 0 while three 1-element windows are offered -> exactly two are accepted and op_din_rdy = 0; after one pop, op_din_rdy = 1 and the results emerge in order.
REQ-042 Overflow test: 10 elements offered with no eop (MAX_WIN = 9) -> ovf_err = 1 after the 10th acceptance and still 1 after a following eop, and cleared only by rst.
REQ-043 Reset test: rst pulsed after 4 elements of a window -> no output is produced, and a following 1-element window of value 5 gives 5.
REQ-044 Simultaneous push/pop test: with the FIFO holding one entry, blob_dout_rdy = 1 and the stage valid -> fifo_count stays 1, and the output sequence is correct.
